// File: rtl/dsp48_pkg.sv
// Shared constants and helpers for the DSP48-style pipeline register slice.
// Sizes the lat_sel/fill ports consistently across the modules that import it.
package dsp48_pkg;

    localparam int MAX_DEPTH     = 8;
    localparam int DEFAULT_WIDTH = 18;

    // Bits needed to encode 0..depth, used for both lat_sel and fill.
    function automatic int lat_sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One pipeline stage: a single {valid, data} register with async reset,
// synchronous clear and clock enable (priority reset > clr > ce).
module dsp_pipe_stage
    import dsp48_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    input  logic           clr,
    input  logic [WIDTH:0] d,
    output logic [WIDTH:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the chain shifts correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {1'b0, RESET_VAL};
        end else if (clr) begin
            q <= {1'b0, RESET_VAL};
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_pipe_reg.sv
// Variable-latency pipeline register: DEPTH stages of {valid, data} with a
// runtime-selectable output tap (0 = bypass) and a count of valid stages.
module dsp_pipe_reg
    import dsp48_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    input  logic                             clr,
    input  logic [lat_sel_width(DEPTH)-1:0]  lat_sel,
    input  logic [WIDTH-1:0]                 din,
    input  logic                             din_vld,
    output logic [WIDTH-1:0]                 dout,
    output logic                             dout_vld,
    output logic [lat_sel_width(DEPTH)-1:0]  fill
);

    localparam int             LW      = lat_sel_width(DEPTH);
    localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);

    logic [WIDTH:0]  stage_d [DEPTH];
    logic [WIDTH:0]  stage_q [DEPTH];
    logic [DEPTH-1:0] vld_bits;
    logic [LW-1:0]   lat_eff;
    logic [WIDTH:0]  tap;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_d[k] = {din_vld, din};
        end else begin : g_body
            assign stage_d[k] = stage_q[k-1];
        end

        dsp_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .ce    (ce),
            .clr   (clr),
            .d     (stage_d[k]),
            .q     (stage_q[k])
        );

        assign vld_bits[k] = stage_q[k][WIDTH];
    end

    // Out-of-range latency requests saturate to the deepest tap.
    assign lat_eff = (lat_sel > DEPTH_L) ? DEPTH_L : lat_sel;

    // NOTE: tap gets a default before the selection loop so no latch is inferred.
    always_comb begin
        tap = {din_vld, din};
        for (int k = 0; k < DEPTH; k++) begin
            if (lat_eff == LW'(k + 1)) begin
                tap = stage_q[k];
            end
        end
    end

    assign dout     = tap[WIDTH-1:0];
    assign dout_vld = tap[WIDTH];

    // Derived only from registered valid bits; din_vld never reaches fill.
    assign fill = LW'($countones(vld_bits));

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Directed bench for dsp_pipe_reg with DEPTH=2 and a non-zero reset value,
// one task per feature, all expectations hand-computed.
module tb_dsp_pipe_reg;

    localparam int          WIDTH = 18;
    localparam int          DEPTH = 2;
    localparam logic [17:0] RV    = 18'h15A5A;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        clr;
    logic [1:0]  lat_sel;
    logic [17:0] din;
    logic        din_vld;
    logic [17:0] dout;
    logic        dout_vld;
    logic [1:0]  fill;

    int checks = 0;
    int errors = 0;

    dsp_pipe_reg #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .clr      (clr),
        .lat_sel  (lat_sel),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .fill     (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0; clr = 1'b0; lat_sel = 2'd2;
        din = 18'h0; din_vld = 1'b0;
        #1;
        checks++;
        if (dout !== RV) begin
            errors++; $display("FAIL reset_dout: got %h expected %h", dout, RV);
        end
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld: got %b expected 0", dout_vld);
        end
        checks++;
        if (fill !== 2'd0) begin
            errors++; $display("FAIL reset_fill: got %0d expected 0", fill);
        end
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_stream();
        logic [17:0] exp_d [3];
        logic        exp_v [3];
        logic [1:0]  exp_f [3];
        exp_d = '{RV, 18'h00001, 18'h00002};
        exp_v = '{1'b0, 1'b1, 1'b1};
        exp_f = '{2'd1, 2'd2, 2'd2};
        ce = 1'b1; lat_sel = 2'd2; din_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 18'(i + 1);
            step();
            checks++;
            if (dout !== exp_d[i] || dout_vld !== exp_v[i]) begin
                errors++;
                $display("FAIL stream_out[%0d]: got %h/%b expected %h/%b",
                         i, dout, dout_vld, exp_d[i], exp_v[i]);
            end
            checks++;
            if (fill !== exp_f[i]) begin
                errors++; $display("FAIL stream_fill[%0d]: got %0d expected %0d", i, fill, exp_f[i]);
            end
        end
    endtask

    // Pipeline holds {2,3}; freeze 3 edges, then resume with 4,5, a bubble and 7.
    task automatic test_stall();
        logic [17:0] exp_d [4];
        logic        exp_v [4];
        logic [1:0]  exp_f [4];
        logic [17:0] in_d  [4];
        logic        in_v  [4];
        ce = 1'b0; din = 18'h00004; din_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dout !== 18'h00002 || dout_vld !== 1'b1 || fill !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h/%b/%0d expected 00002/1/2",
                         i, dout, dout_vld, fill);
            end
        end
        in_d  = '{18'h00004, 18'h00005, 18'h00006, 18'h00007};
        in_v  = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_d = '{18'h00003, 18'h00004, 18'h00005, 18'h00006};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_f = '{2'd2, 2'd2, 2'd1, 2'd1};
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = in_d[i]; din_vld = in_v[i];
            step();
            checks++;
            if (dout !== exp_d[i] || dout_vld !== exp_v[i] || fill !== exp_f[i]) begin
                errors++;
                $display("FAIL stall_resume[%0d]: got %h/%b/%0d expected %h/%b/%0d",
                         i, dout, dout_vld, fill, exp_d[i], exp_v[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_clear();
        din = 18'h00008; din_vld = 1'b1; ce = 1'b1;
        step();
        checks++;
        if (fill !== 2'd2) begin
            errors++; $display("FAIL clear_pre_fill: got %0d expected 2", fill);
        end
        ce = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (dout !== RV || dout_vld !== 1'b0 || fill !== 2'd0) begin
            errors++;
            $display("FAIL clear: got %h/%b/%0d expected %h/0/0", dout, dout_vld, fill, RV);
        end
    endtask

    task automatic test_bypass_and_saturate();
        ce = 1'b0; lat_sel = 2'd0;
        din = 18'h2AAAA; din_vld = 1'b1;
        #1;
        checks++;
        if (dout !== 18'h2AAAA || dout_vld !== 1'b1) begin
            errors++; $display("FAIL bypass_a: got %h/%b expected 2aaaa/1", dout, dout_vld);
        end
        din = 18'h12345; din_vld = 1'b0;
        #1;
        checks++;
        if (dout !== 18'h12345 || dout_vld !== 1'b0) begin
            errors++; $display("FAIL bypass_b: got %h/%b expected 12345/0", dout, dout_vld);
        end
        ce = 1'b1; din_vld = 1'b1;
        din = 18'h00011;
        step();
        din = 18'h00022;
        step();
        ce = 1'b0;
        lat_sel = 2'd3;
        #1;
        checks++;
        if (dout !== 18'h00011 || dout_vld !== 1'b1) begin
            errors++; $display("FAIL lat3_sat: got %h/%b expected 00011/1", dout, dout_vld);
        end
    endtask

    // Stages hold {0x22, 0x11}; retarget the tap between edges while streaming.
    task automatic test_lat_switch();
        ce = 1'b1; din = 18'h00033; din_vld = 1'b1;
        lat_sel = 2'd2;
        #1;
        checks++;
        if (dout !== 18'h00011) begin
            errors++; $display("FAIL switch_tap2: got %h expected 00011", dout);
        end
        lat_sel = 2'd1;
        #1;
        checks++;
        if (dout !== 18'h00022 || dout_vld !== 1'b1 || fill !== 2'd2) begin
            errors++; $display("FAIL switch_tap1: got %h/%b/%0d expected 00022/1/2", dout, dout_vld, fill);
        end
        step();
        checks++;
        if (dout !== 18'h00033) begin
            errors++; $display("FAIL switch_tap1_next: got %h expected 00033", dout);
        end
        lat_sel = 2'd2;
        #1;
        checks++;
        if (dout !== 18'h00022) begin
            errors++; $display("FAIL switch_contents: got %h expected 00022", dout);
        end
    endtask

    task automatic test_async_reset();
        ce = 1'b1; din = 18'h00044; din_vld = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dout !== RV || dout_vld !== 1'b0 || fill !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got %h/%b/%0d expected %h/0/0", dout, dout_vld, fill, RV);
        end
        step();
        reset = 1'b0;
        lat_sel = 2'd0;
        #1;
        checks++;
        if (dout !== 18'h00044) begin
            errors++; $display("FAIL post_reset_bypass: got %h expected 00044", dout);
        end
        lat_sel = 2'd2;
        step();
        checks++;
        if (dout !== RV || dout_vld !== 1'b0 || fill !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_first: got %h/%b/%0d expected %h/0/1", dout, dout_vld, fill, RV);
        end
        din = 18'h00055;
        step();
        checks++;
        if (dout !== 18'h00044 || dout_vld !== 1'b1 || fill !== 2'd2) begin
            errors++;
            $display("FAIL post_reset_second: got %h/%b/%0d expected 00044/1/2", dout, dout_vld, fill);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_clear();
        test_bypass_and_saturate();
        test_lat_switch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_pipe_reg.md
DSP_PIPE_REG -- requirements
Module: dsp_pipe_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 18, as the data width in bits (legal range 1..48).
REQ-002 The block SHALL take parameter DEPTH, default 2, as the number of physical pipeline stages (legal range 1..8).
REQ-003 The block SHALL take parameter RESET_VAL, default 0, as the WIDTH-bit value loaded into every data stage on reset or clear.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port ce, input, 1 bit: clock enable for all stages.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear, active-high.
REQ-008 The block SHALL have port lat_sel, input, $clog2(DEPTH+1) bits: selected latency in cycles, 0 = bypass.
REQ-009 The block SHALL have port din, input, WIDTH bits: data in.
REQ-010 The block SHALL have port din_vld, input, 1 bit: data-in valid qualifier.
REQ-011 The block SHALL have port dout, output, WIDTH bits: data at the selected tap.
REQ-012 The block SHALL have port dout_vld, output, 1 bit: valid at the selected tap.
REQ-013 The block SHALL have port fill, output, $clog2(DEPTH+1) bits: count of stages currently holding valid data.

Function
REQ-014 On a clk edge with ce=1 and clr=0, stage 0 SHALL load {din_vld, din} and stage k SHALL load stage k-1, for k = 1..DEPTH-1.
REQ-015 With ce=0 and clr=0, all stages SHALL hold their value.
REQ-016 With clr=1 on a clk edge, every data stage SHALL load RESET_VAL and every valid bit SHALL load 0, regardless of ce.
REQ-017 With lat_sel=0, dout/dout_vld SHALL equal din/din_vld combinationally (zero latency).
REQ-018 With lat_sel=n, 1<=n<=DEPTH, dout/dout_vld SHALL equal stage n-1, giving a latency of n enabled cycles.
REQ-019 lat_sel>DEPTH SHALL be treated as DEPTH.
REQ-020 A change of lat_sel SHALL switch the output tap in the same cycle without disturbing stage contents.
REQ-021 fill SHALL equal the number of set valid bits across all DEPTH stages, registered-state derived with no combinational path from din_vld.
REQ-022 An invalid beat (din_vld=0) SHALL still advance through the stages, so data and valid stay aligned.

Reset
REQ-023 While reset=1, all data stages SHALL equal RESET_VAL and all valid bits 0 immediately, independent of clk.
REQ-024 After reset, dout SHALL equal RESET_VAL for lat_sel>=1, dout_vld SHALL be 0, and fill SHALL be 0.
REQ-025 Reset SHALL take priority over clr, and clr SHALL take priority over ce.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight beats, with no partial output afterwards.

Structure
REQ-027 Shared package dsp48_pkg SHALL hold MAX_DEPTH=8, the default WIDTH of 18, and a function computing the lat_sel width.
REQ-028 One sub-module, dsp_pipe_stage, SHALL be used: a single WIDTH+1-bit register with async reset, sync clear and ce, instantiated DEPTH times via generate.
REQ-029 The output tap mux and the fill popcount SHALL live in the top level.

Verification
REQ-030 With DEPTH=2 and lat_sel=2, drive din=0x00001,0x00002,0x00003 with vld=1 and ce=1 -> dout shows 0x00001 two edges after its input, and fill goes 1,2,2.
REQ-031 With ce=0 for 3 cycles mid-stream -> dout, dout_vld and fill are frozen; the stream resumes in order with no loss or duplication.
REQ-032 With clr=1 while ce=0 and fill=2 -> on the next edge dout=RESET_VAL, dout_vld=0, fill=0.
REQ-033 With lat_sel=0 -> dout follows din in the same cycle; with lat_sel=3 on DEPTH=2 -> behaves as lat_sel=2.
REQ-034 Assert reset between edges with fill=2 -> outputs go to reset values immediately, before the next clk edge.
REQ-035 Switch lat_sel 2->1 mid-stream with DEPTH=2 -> dout jumps to stage 0 that cycle, and stage contents are unchanged.
